// File: rtl/espacc_dma_pkg.sv
// Shared types and constants for the ESP accelerator DMA read path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package espacc_dma_pkg;

  // DMA ctrl field widths
  localparam int INDEX_W = 32;
  localparam int LEN_W   = 32;
  localparam int SIZE_W  = 3;

  // Word size codes carried on the ctrl size field
  localparam logic [SIZE_W-1:0] SIZE_BYTE  = 3'b000;
  localparam logic [SIZE_W-1:0] SIZE_HWORD = 3'b001;
  localparam logic [SIZE_W-1:0] SIZE_WORD  = 3'b010;
  localparam logic [SIZE_W-1:0] SIZE_DWORD = 3'b011;

  // Read splitter FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DATA  = 2'd2
  } rd_state_t;

  // Length of the next chunk: whatever is left, capped at the burst limit.
  function automatic logic [LEN_W-1:0] chunk_len(input logic [LEN_W-1:0] remaining,
                                                 input logic [LEN_W-1:0] max_burst);
    return (remaining < max_burst) ? remaining : max_burst;
  endfunction

endpackage

// File: rtl/espacc_rtl_dma_read_splitter.sv
// Splits one core DMA read request into sequential socket bursts of at most MAX_BURST beats.
// Latency: chunk request registered one cycle after acceptance/last beat; read beats pass through combinationally.
// Backpressure: one chunk outstanding; beats stall on acc_chnl_ready; socket beats are held off outside DATA.
module espacc_rtl_dma_read_splitter
  import espacc_dma_pkg::*;
#(
  parameter int unsigned DMA_BUS_WIDTH = 64,
  parameter int unsigned MAX_BURST     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  // core read request
  input  logic                     acc_ctrl_valid,
  output logic                     acc_ctrl_ready,
  input  logic [INDEX_W-1:0]       acc_ctrl_index,
  input  logic [LEN_W-1:0]         acc_ctrl_length,
  input  logic [SIZE_W-1:0]        acc_ctrl_size,
  // socket chunk request
  output logic                     dma_read_ctrl_valid,
  input  logic                     dma_read_ctrl_ready,
  output logic [INDEX_W-1:0]       dma_read_ctrl_data_index,
  output logic [LEN_W-1:0]         dma_read_ctrl_data_length,
  output logic [SIZE_W-1:0]        dma_read_ctrl_data_size,
  // socket read channel
  input  logic                     dma_read_chnl_valid,
  output logic                     dma_read_chnl_ready,
  input  logic [DMA_BUS_WIDTH-1:0] dma_read_chnl_data,
  // core read channel
  output logic                     acc_chnl_valid,
  input  logic                     acc_chnl_ready,
  output logic [DMA_BUS_WIDTH-1:0] acc_chnl_data,
  // status
  output logic                     busy,
  output logic                     req_done
);

  localparam logic [LEN_W-1:0] MAX_BURST_LEN = LEN_W'(MAX_BURST);

  rd_state_t          state;
  rd_state_t          state_nxt;
  logic [INDEX_W-1:0] cur_index;
  logic [LEN_W-1:0]   remaining;
  logic [LEN_W-1:0]   beats_left;

  logic               beat_hs;
  logic               last_beat;
  logic [LEN_W-1:0]   rem_after;
  logic [INDEX_W-1:0] idx_after;

  // The current chunk length lives in the registered ctrl length field, so the
  // post-chunk bookkeeping reuses it rather than keeping a second copy.
  assign beat_hs   = (state == ST_DATA) && dma_read_chnl_valid && acc_chnl_ready;
  assign last_beat = beat_hs && (beats_left == 32'd1);
  assign rem_after = remaining - dma_read_ctrl_data_length;
  assign idx_after = cur_index + dma_read_ctrl_data_length;

  assign busy          = (state != ST_IDLE);
  assign acc_chnl_data = dma_read_chnl_data;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; the read channel is only connected in DATA
  always_comb begin
    state_nxt           = state;
    acc_ctrl_ready      = 1'b0;
    acc_chnl_valid      = 1'b0;
    dma_read_chnl_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        acc_ctrl_ready = 1'b1;
        if (acc_ctrl_valid && (acc_ctrl_length != '0)) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (dma_read_ctrl_ready) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        acc_chnl_valid      = dma_read_chnl_valid;
        dma_read_chnl_ready = acc_chnl_ready;
        if (last_beat) begin
          state_nxt = (rem_after == '0) ? ST_IDLE : ST_ISSUE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Socket request fields: loaded on entry to ISSUE, held until the socket takes them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dma_read_ctrl_valid       <= 1'b0;
      dma_read_ctrl_data_index  <= '0;
      dma_read_ctrl_data_length <= '0;
      dma_read_ctrl_data_size   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (acc_ctrl_valid && (acc_ctrl_length != '0)) begin
            dma_read_ctrl_valid       <= 1'b1;
            dma_read_ctrl_data_index  <= acc_ctrl_index;
            dma_read_ctrl_data_length <= chunk_len(acc_ctrl_length, MAX_BURST_LEN);
            dma_read_ctrl_data_size   <= acc_ctrl_size;
          end
        end
        ST_ISSUE: begin
          if (dma_read_ctrl_ready) begin
            dma_read_ctrl_valid <= 1'b0;
          end
        end
        ST_DATA: begin
          if (last_beat && (rem_after != '0)) begin
            dma_read_ctrl_valid       <= 1'b1;
            dma_read_ctrl_data_index  <= idx_after;
            dma_read_ctrl_data_length <= chunk_len(rem_after, MAX_BURST_LEN);
          end
        end
        default: begin
          dma_read_ctrl_valid <= 1'b0;
        end
      endcase
    end
  end

  // Request progress counters; cur_index wraps modulo 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_index  <= '0;
      remaining  <= '0;
      beats_left <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (acc_ctrl_valid) begin
            cur_index <= acc_ctrl_index;
            remaining <= acc_ctrl_length;
          end
        end
        ST_ISSUE: begin
          if (dma_read_ctrl_ready) begin
            beats_left <= dma_read_ctrl_data_length;
          end
        end
        ST_DATA: begin
          if (beat_hs) begin
            beats_left <= beats_left - 32'd1;
            if (beats_left == 32'd1) begin
              remaining <= rem_after;
              cur_index <= idx_after;
            end
          end
        end
        default: begin
          beats_left <= '0;
        end
      endcase
    end
  end

  // One-cycle completion pulse: zero-length accept or last beat of the final chunk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_done <= 1'b0;
    end else begin
      req_done <= ((state == ST_IDLE) && acc_ctrl_valid && (acc_ctrl_length == '0)) ||
                  (last_beat && (rem_after == '0));
    end
  end

endmodule

// File: doc/espacc_rtl_dma_read_splitter.md
Name: espacc_rtl_dma_read_splitter

Overview:
- Sits between the ESP socket DMA read interface and the accelerator core's read ctrl/chnl ports. Accelerator core is upstream on ctrl; socket is upstream on data.
- Accepts one arbitrary-length read request from the core and issues it to the socket as sequential chunks of at most MAX_BURST beats.
- Passes read-channel beats from the socket through to the core and counts them.
- Only one chunk is outstanding at a time. The next chunk is issued only after all beats of the current chunk have been delivered.

Parameters:
- DMA_BUS_WIDTH, 64, read channel data width in bits.
- MAX_BURST, 16, maximum beats per downstream request. Legal range is 1 to 2^16.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- acc_ctrl_valid  in  1  core read request valid
- acc_ctrl_ready  out  1  splitter can accept a request
- acc_ctrl_index  in  32  start index, in beats
- acc_ctrl_length  in  32  total length, in beats
- acc_ctrl_size  in  3  word size code, passed through unchanged
- dma_read_ctrl_valid  out  1  chunk request to socket
- dma_read_ctrl_ready  in  1  socket accepts chunk
- dma_read_ctrl_data_index  out  32  chunk start index
- dma_read_ctrl_data_length  out  32  chunk length, 1 to MAX_BURST
- dma_read_ctrl_data_size  out  3  latched acc_ctrl_size
- dma_read_chnl_valid  in  1  socket beat valid
- dma_read_chnl_ready  out  1  splitter/core accepts beat
- dma_read_chnl_data  in  DMA_BUS_WIDTH  socket beat data
- acc_chnl_valid  out  1  beat to core
- acc_chnl_ready  in  1  core accepts beat
- acc_chnl_data  out  DMA_BUS_WIDTH  beat data to core
- busy  out  1  high when the FSM is not in IDLE
- req_done  out  1  one-cycle pulse when a full request completes

Behaviour:
- Clock and reset: single clock domain. rst is asynchronous and active-high and clears all state.
- Reset values:
  - state = IDLE
  - dma_read_ctrl_valid = 0
  - dma_read_ctrl_data_index / _length / _size = 0
  - req_done = 0, busy = 0
  - all internal counters = 0
- FSM states: IDLE, ISSUE, DATA.
- IDLE:
  - acc_ctrl_ready = 1.
  - On acc_ctrl_valid && acc_ctrl_ready: latch cur_index = index, remaining = length, size.
  - If length == 0: stay in IDLE and pulse req_done on the next cycle. No socket request is issued.
  - Otherwise go to ISSUE.
- ISSUE:
  - dma_read_ctrl_valid = 1 (registered, asserted the cycle after acceptance).
  - data_index = cur_index.
  - data_length = chunk = min(remaining, MAX_BURST).
  - valid, index, length and size are held stable until ready is seen.
  - On dma_read_ctrl_ready: beats_left = chunk, go to DATA.
- DATA:
  - Combinational passthrough:
    - acc_chnl_valid = dma_read_chnl_valid
    - dma_read_chnl_ready = acc_chnl_ready
    - acc_chnl_data = dma_read_chnl_data
  - Each beat handshake (valid && ready on both sides, i.e. a single transfer) decrements beats_left.
  - On the last beat (beats_left == 1 and a handshake):
    - remaining -= chunk
    - cur_index += chunk, with mod-2^32 wrap
  - After the last beat:
    - If the new remaining == 0: go to IDLE, req_done = 1 for exactly the next cycle.
    - Otherwise go to ISSUE, with dma_read_ctrl_valid asserted the next cycle.
- Outside DATA: acc_chnl_valid = 0 and dma_read_chnl_ready = 0. Stray socket beats are back-pressured, never dropped.
- acc_ctrl_ready is 0 in ISSUE and DATA.
- Back-to-back requests: a new request is accepted in the first IDLE cycle, i.e. the cycle req_done is high.
- Arithmetic: all counters are 32-bit unsigned. MAX_BURST is compared zero-extended to 32 bits.
- busy = (state != IDLE).
- Reset mid-transfer: the FSM returns to IDLE and the outstanding socket request is abandoned. The system resets the socket together with this block.

Decomposition:
- Shared package espacc_dma_pkg:
  - FSM state encoding (2-bit enum)
  - DMA ctrl field widths (INDEX_W = 32, LEN_W = 32, SIZE_W = 3)
  - size code constants (e.g. SIZE_DWORD = 3'b011)
- No sub-module. Single module of roughly 150-200 lines.

Test Plan:
- Request index=0x100, length=40, MAX_BURST=16, ready always high, then deliver 40 beats:
  - socket sees chunks (0x100,16), (0x110,16), (0x120,8)
  - 40 beats reach the core in order
  - req_done pulses once, after beat 40
- length=0 request -> no dma_read_ctrl_valid ever; req_done pulses 1 cycle after acceptance; acc_ctrl_ready returns high.
- Hold dma_read_ctrl_ready low 5 cycles during ISSUE -> valid, index, length and size stay constant; no chnl handshake occurs.
- Toggle acc_chnl_ready every other cycle with length=16 -> dma_read_chnl_ready mirrors it; beats_left reaches 0 after exactly 16 handshakes; no beat is duplicated or lost.
- Request index=0xFFFFFFF8, length=20 -> chunks at 0xFFFFFFF8 (16 beats) and 0x00000008 (4 beats), showing the index wrap.
- Assert rst during DATA after 3 of 16 beats -> next cycle all outputs are at reset values, busy = 0, acc_ctrl_ready = 1 after release.
